exe_div_ctrl: RTL

- Sequencer for the iterative 32-bit divider used by the EXE stage for div.w/div.wu/mod.w/mod.wu.
- Accepts one request at a time and runs a 32-step restoring divide on operand magnitudes, then applies sign correction.
- Holds the result until EXE/MEM backpressure releases it.
- Honours pipeline flush (exception/ertn cancel) in any state.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/div_step.sv | 27 ++
 rtl/exe_div_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the EXE-stage iterative divider.
// Imported by the divider controller and its restoring-step datapath.
package cpu_pkg;

  localparam int DIV_WIDTH = 32;

  // Quotient reported for any divide by zero.
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it is non-negative.
module div_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             quot_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted  = {rem_in[WIDTH-1:0], dividend_bit};
    diff     = {1'b0, shifted} - {2'b00, divisor};
    // A set top bit on entry means the true shifted value exceeds any divisor,
    // so the subtract always succeeds and the modular difference is exact.
    quot_bit = rem_in[WIDTH] | ~diff[WIDTH+1];
    rem_out  = quot_bit ? diff[WIDTH:0] : shifted;
  end

endmodule

// File: rtl/exe_div_ctrl.sv
// Sequencer for the EXE-stage 32-step restoring divider: magnitude divide,
// sign fixup, result hold under backpressure, and flush on cancel.
module exe_div_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  input  logic             cancel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_quot,
  output logic [WIDTH-1:0] res_rem,
  output logic             res_dbz,
  output logic             busy
);

  // Handshakes: a request transfers on a clock edge where req_valid & req_ready;
  // a result transfers where res_valid & res_ready. res_valid never depends
  // combinationally on inputs, and held results stay stable until taken.

  localparam int CW = $clog2(WIDTH);

  div_state_e       state;
  div_state_e       next_state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   part_rem;
  logic [WIDTH-1:0] dq;        // dividend bits shift out the top, quotient bits in at the bottom
  logic [WIDTH-1:0] y_mag;
  logic             neg_quot;
  logic             neg_rem;
  logic             accept;
  logic             req_dbz;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  assign req_dbz = (req_y == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (part_rem),
    .dividend_bit (dq[WIDTH-1]),
    .divisor      (y_mag),
    .rem_out      (step_rem),
    .quot_bit     (step_q)
  );

  always_comb begin
    next_state = state;
    req_ready  = ~cancel & ((state == IDLE) | ((state == DONE) & res_ready));
    accept     = req_valid & req_ready;
    case (state)
      IDLE: if (accept) next_state = req_dbz ? DONE : ITER;
      ITER: if (count == CW'(WIDTH - 1)) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: begin
        if (accept)         next_state = req_dbz ? DONE : ITER;
        else if (res_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (cancel) next_state = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      res_valid <= (next_state == DONE);
      busy      <= (next_state != IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      part_rem <= '0;
      dq       <= '0;
      y_mag    <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      res_quot <= '0;
      res_rem  <= '0;
      res_dbz  <= 1'b0;
    end else begin
      if (accept) begin
        count    <= '0;
        part_rem <= '0;
        dq       <= (req_signed & req_x[WIDTH-1]) ? -req_x : req_x;
        y_mag    <= (req_signed & req_y[WIDTH-1]) ? -req_y : req_y;
        neg_quot <= req_signed & (req_x[WIDTH-1] ^ req_y[WIDTH-1]);
        neg_rem  <= req_signed & req_x[WIDTH-1];
        if (req_dbz) begin
          res_quot <= DBZ_QUOT;
          res_rem  <= req_x;
          res_dbz  <= 1'b1;
        end
      end else if (state == ITER) begin
        count    <= count + 1'b1;
        part_rem <= step_rem;
        dq       <= {dq[WIDTH-2:0], step_q};
      end
      // Results load only when FIX actually hands over to DONE.
      if ((state == FIX) && !cancel) begin
        res_quot <= neg_quot ? -dq : dq;
        res_rem  <= WIDTH'(neg_rem ? -part_rem : part_rem);
        res_dbz  <= 1'b0;
      end
    end
  end

endmodule
